// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package mem_arb_pkg;

  localparam int MEM_ARB_ADDR_W  = 64;
  localparam int MEM_ARB_BLOCK_W = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Latched request. Fields use the default widths, so an arbiter instance
  // may be narrower but never wider than these.
  typedef struct packed {
    logic [MEM_ARB_ADDR_W-1:0]  addr;
    logic                       wr;
    logic [MEM_ARB_BLOCK_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational rotating picker: first asserted request at or after ptr.
// Tying ptr to zero turns it into a lowest-index-wins priority picker.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDW-1:0]     gnt_idx,
  output logic               gnt_valid
);

  // Explicit wrap so non-power-of-2 channel counts rotate correctly.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end else begin
      s = s;
    end
    return IDW'(s);
  endfunction

  // Scan from the pointer and stop at the first asserted request.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!gnt_valid && req[wrap_idx(ptr, off)]) begin
        gnt_valid                  = 1'b1;
        gnt_idx                    = wrap_idx(ptr, off);
        gnt_oh[wrap_idx(ptr, off)] = 1'b1;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel block-request arbiter in front of the single memory_controller
// port. One transaction at a time: grant, issue, wait, respond.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = MEM_ARB_ADDR_W,
  parameter int BLOCK_WIDTH = MEM_ARB_BLOCK_W,
  parameter int RR_MODE     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*BLOCK_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             done,
  output logic [BLOCK_WIDTH-1:0]         rdata,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           mem_req,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_wr_en,
  output logic [BLOCK_WIDTH-1:0]         mem_wdata,
  input  logic                           mem_data_valid,
  input  logic [BLOCK_WIDTH-1:0]         mem_rdata
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_t             state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         gid_q, gid_d;
  mem_req_t               lat_q, lat_d;
  logic                   mem_req_q, mem_req_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [BLOCK_WIDTH-1:0] rdata_q, rdata_d;
  logic                   busy_q, busy_d;

  logic [IDW-1:0]         pick_ptr;
  logic [NUM_REQ-1:0]     pick_oh;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_valid;
  mem_req_t               sel_req;

  // Fixed priority is the rotating picker with its pointer pinned at zero.
  assign pick_ptr = (RR_MODE != 0) ? ptr_q : {IDW{1'b0}};

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req       (req_valid),
    .ptr       (pick_ptr),
    .gnt_oh    (pick_oh),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  // One-hot mux of the winning channel's address, direction and write block.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        sel_req.addr  = MEM_ARB_ADDR_W'(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
        sel_req.wr    = req_wr[i];
        sel_req.wdata = MEM_ARB_BLOCK_W'(req_wdata[i*BLOCK_WIDTH +: BLOCK_WIDTH]);
      end else begin
        sel_req = sel_req;
      end
    end
  end

  // Next-state and next-output logic; grant is locked from ISSUE through RESP.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    mem_req_d = 1'b0;
    done_d    = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gid_d     = pick_idx;
          lat_d     = sel_req;
          mem_req_d = 1'b1;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_data_valid) begin
          if (!lat_q.wr) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          done_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << gid_q;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (gid_q == IDW'(NUM_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = gid_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      lat_q     <= '0;
      rdata_q   <= '0;
      mem_req_q <= 1'b0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      lat_q     <= lat_d;
      rdata_q   <= rdata_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign done      = done_q;
  assign rdata     = rdata_q;
  assign grant_id  = gid_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = lat_q.addr[ADDR_WIDTH-1:0];
  assign mem_wr_en = lat_q.wr;
  assign mem_wdata = lat_q.wdata[BLOCK_WIDTH-1:0];

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: a 2-channel RR arbiter with hand-timed memory responses,
// plus 3-channel RR and fixed-priority arbiters behind a fixed-latency model.
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- 2-channel, default widths, round-robin ----------------
  logic [1:0]    r2_valid, r2_wr;
  logic [127:0]  r2_addr;
  logic [1023:0] r2_wdata;
  logic [1:0]    d2_done;
  logic [511:0]  d2_rdata;
  logic [0:0]    d2_gid;
  logic          d2_busy, d2_mem_req, d2_wr_en;
  logic [63:0]   d2_mem_addr;
  logic [511:0]  d2_mem_wdata;
  logic          m2_dv;
  logic [511:0]  m2_rdata;

  mem_arbiter_rr #(.NUM_REQ(2), .RR_MODE(1)) dut2 (
    .clk(clk), .reset(reset), .req_valid(r2_valid), .req_wr(r2_wr),
    .req_addr(r2_addr), .req_wdata(r2_wdata), .done(d2_done), .rdata(d2_rdata),
    .grant_id(d2_gid), .busy(d2_busy), .mem_req(d2_mem_req), .mem_addr(d2_mem_addr),
    .mem_wr_en(d2_wr_en), .mem_wdata(d2_mem_wdata), .mem_data_valid(m2_dv),
    .mem_rdata(m2_rdata)
  );

  // ---------------- 3-channel, narrow widths, RR and fixed ----------------
  logic [2:0]  r3_valid, r3f_valid;
  logic [2:0]  d3_done, d3f_done;
  logic [31:0] d3_rdata, d3f_rdata;
  logic [1:0]  d3_gid, d3f_gid;
  logic        d3_busy, d3f_busy, d3_mem_req, d3f_mem_req, d3_wr_en, d3f_wr_en;
  logic [15:0] d3_mem_addr, d3f_mem_addr;
  logic [31:0] d3_mem_wdata, d3f_mem_wdata;
  logic [1:0]  m3_sr, m3f_sr;

  mem_arbiter_rr #(.NUM_REQ(3), .ADDR_WIDTH(16), .BLOCK_WIDTH(32), .RR_MODE(1)) dut3 (
    .clk(clk), .reset(reset), .req_valid(r3_valid), .req_wr(3'b000),
    .req_addr(48'h0003_0002_0001), .req_wdata(96'h0), .done(d3_done), .rdata(d3_rdata),
    .grant_id(d3_gid), .busy(d3_busy), .mem_req(d3_mem_req), .mem_addr(d3_mem_addr),
    .mem_wr_en(d3_wr_en), .mem_wdata(d3_mem_wdata), .mem_data_valid(m3_sr[1]),
    .mem_rdata({16'h0, d3_mem_addr})
  );

  mem_arbiter_rr #(.NUM_REQ(3), .ADDR_WIDTH(16), .BLOCK_WIDTH(32), .RR_MODE(0)) dut3f (
    .clk(clk), .reset(reset), .req_valid(r3f_valid), .req_wr(3'b000),
    .req_addr(48'h0003_0002_0001), .req_wdata(96'h0), .done(d3f_done), .rdata(d3f_rdata),
    .grant_id(d3f_gid), .busy(d3f_busy), .mem_req(d3f_mem_req), .mem_addr(d3f_mem_addr),
    .mem_wr_en(d3f_wr_en), .mem_wdata(d3f_mem_wdata), .mem_data_valid(m3f_sr[1]),
    .mem_rdata({16'h0, d3f_mem_addr})
  );

  // Fixed-latency memory models: completion two cycles after mem_req.
  always @(posedge clk) begin
    if (reset) begin
      m3_sr  <= 2'b00;
      m3f_sr <= 2'b00;
    end else begin
      m3_sr  <= {m3_sr[0], d3_mem_req};
      m3f_sr <= {m3f_sr[0], d3f_mem_req};
    end
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a done pulse on a 3-channel instance; 0 means timeout.
  task automatic wait_done(input int sel, output logic [2:0] d);
    d = 3'b000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d = (sel == 0) ? d3_done : d3f_done;
      if (d != 3'b000) break;
    end
  endtask

  logic [511:0] pat_a5, pat_5a, pat_12, pat_de;
  logic [2:0]   d;
  logic [2:0]   rr_exp;

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_5a = {64{8'h5A}};
    pat_12 = {16{32'h1234_5678}};
    pat_de = {16{32'hDEAD_BEEF}};
    reset = 1'b1; r2_valid = 2'b00; r2_wr = 2'b00; r2_addr = '0; r2_wdata = '0;
    m2_dv = 1'b0; m2_rdata = '0; r3_valid = 3'b000; r3f_valid = 3'b000;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_done", d2_done, 2'b00);
    check_eq("rst_busy", d2_busy, 1'b0);
    check_eq("rst_mem_req", d2_mem_req, 1'b0);
    check_eq("rst_rdata", d2_rdata, 512'h0);
    check_eq("rst_mem_addr", d2_mem_addr, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single read on ch0, memory answers 5 cycles after mem_req
    r2_valid = 2'b01; r2_wr = 2'b00; r2_addr[63:0] = 64'h1000;          // cycle 0
    @(negedge clk);                                                     // cycle 1
    check_eq("rd_mem_req", d2_mem_req, 1'b1);
    check_eq("rd_mem_addr", d2_mem_addr, 64'h1000);
    check_eq("rd_wr_en", d2_wr_en, 1'b0);
    check_eq("rd_grant", d2_gid, 1'b0);
    @(negedge clk);                                                     // cycle 2
    check_eq("rd_req_pulse", d2_mem_req, 1'b0);
    check_eq("rd_busy", d2_busy, 1'b1);
    repeat (4) @(negedge clk);                                          // cycle 6
    check_eq("rd_no_early_done", d2_done, 2'b00);
    m2_dv = 1'b1; m2_rdata = pat_a5;
    @(negedge clk);                                                     // cycle 7
    m2_dv = 1'b0; m2_rdata = '0;
    check_eq("rd_done", d2_done, 2'b01);
    check_eq("rd_rdata", d2_rdata, pat_a5);
    r2_valid = 2'b00;
    @(negedge clk);
    check_eq("rd_done_1cyc", d2_done, 2'b00);
    check_eq("rd_idle_busy", d2_busy, 1'b0);

    // Write on ch1, memory answers 3 cycles after mem_req
    r2_valid = 2'b10; r2_wr = 2'b10; r2_addr[127:64] = 64'h2040; r2_wdata[1023:512] = pat_de;
    @(negedge clk);                                                     // cycle 1
    check_eq("wr_mem_req", d2_mem_req, 1'b1);
    check_eq("wr_wr_en", d2_wr_en, 1'b1);
    check_eq("wr_mem_addr", d2_mem_addr, 64'h2040);
    check_eq("wr_mem_wdata", d2_mem_wdata, pat_de);
    check_eq("wr_grant", d2_gid, 1'b1);
    repeat (3) @(negedge clk);                                          // cycle 4
    m2_dv = 1'b1; m2_rdata = pat_5a;
    @(negedge clk);                                                     // cycle 5
    m2_dv = 1'b0;
    check_eq("wr_done", d2_done, 2'b10);
    check_eq("wr_rdata_kept", d2_rdata, pat_a5);
    r2_valid = 2'b00; r2_wr = 2'b00;
    @(negedge clk);

    // Withdrawal in WAIT, then a spurious completion in IDLE
    r2_valid = 2'b01; r2_addr[63:0] = 64'h3000;                         // cycle 0
    @(negedge clk);                                                     // cycle 1
    check_eq("wd_grant", d2_gid, 1'b0);
    @(negedge clk);                                                     // cycle 2
    r2_valid = 2'b00;
    @(negedge clk);                                                     // cycle 3
    m2_dv = 1'b1; m2_rdata = pat_12;
    @(negedge clk);                                                     // cycle 4
    m2_dv = 1'b0;
    check_eq("wd_done", d2_done, 2'b01);
    check_eq("wd_rdata", d2_rdata, pat_12);
    @(negedge clk);                                                     // cycle 5, IDLE
    m2_dv = 1'b1; m2_rdata = pat_5a;
    @(negedge clk);
    m2_dv = 1'b0;
    check_eq("sp_no_done", d2_done, 2'b00);
    check_eq("sp_busy", d2_busy, 1'b0);
    check_eq("sp_mem_req", d2_mem_req, 1'b0);
    check_eq("sp_rdata", d2_rdata, pat_12);
    @(negedge clk);
    check_eq("sp_no_done2", d2_done, 2'b00);

    // Reset mid-WAIT on a ch1 write (pointer is 1 beforehand)
    r2_valid = 2'b10; r2_wr = 2'b10;                                    // cycle 0
    @(negedge clk);                                                     // cycle 1
    check_eq("rw_grant", d2_gid, 1'b1);
    @(negedge clk);                                                     // cycle 2, WAIT
    reset = 1'b1; r2_valid = 2'b00; r2_wr = 2'b00;
    @(negedge clk);                                                     // cycle 3
    reset = 1'b0;
    check_eq("rw_busy", d2_busy, 1'b0);
    check_eq("rw_grant0", d2_gid, 1'b0);
    check_eq("rw_wr_en", d2_wr_en, 1'b0);
    check_eq("rw_mem_addr", d2_mem_addr, 64'h0);
    check_eq("rw_mem_wdata", d2_mem_wdata, 512'h0);
    check_eq("rw_rdata", d2_rdata, 512'h0);
    m2_dv = 1'b1; m2_rdata = pat_5a;
    @(negedge clk);                                                     // cycle 4
    m2_dv = 1'b0;
    check_eq("rw_no_done", d2_done, 2'b00);
    check_eq("rw_idle", d2_busy, 1'b0);
    r2_valid = 2'b11;
    @(negedge clk);                                                     // cycle 5
    check_eq("rw_ptr_zero", d2_gid, 1'b0);
    check_eq("rw_mem_req", d2_mem_req, 1'b1);
    @(negedge clk);                                                     // cycle 6
    m2_dv = 1'b1; m2_rdata = pat_a5;
    @(negedge clk);                                                     // cycle 7
    m2_dv = 1'b0;
    check_eq("rw_done", d2_done, 2'b01);
    r2_valid = 2'b00;
    @(negedge clk);

    // 3-channel round-robin fairness: order 0,1,2,0,1,2
    r3_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      rr_exp = 3'b001 << (t % 3);
      wait_done(0, d);
      check_eq($sformatf("rr_done_%0d", t), d, rr_exp);
    end
    r3_valid = 3'b000;

    // 3-channel fixed priority: ch0 wins until it drops, then ch2
    r3f_valid = 3'b101;
    for (int t = 0; t < 4; t++) begin
      wait_done(1, d);
      if (t < 3) begin
        check_eq($sformatf("fx_done_%0d", t), d, 3'b001);
      end else begin
        check_eq("fx_done_ch2", d, 3'b100);
      end
      if (t == 2) r3f_valid = 3'b100;
      else if (t == 3) r3f_valid = 3'b000;
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised successor to the two-port icache/dcache arbiter. Arbitrates NUM_REQ cache-side block requesters onto the single memory_controller port.
- Supports round-robin or fixed-priority grant, block writes, and a registered response that is routed back to the granted requester.
- Sits between the L1 caches (instcache, datacache, and future prefetcher or page-walker ports) and memory_controller.

Parameters:
- NUM_REQ, 2, number of requester channels (≥2); channel 0 is highest priority in fixed mode.
- ADDR_WIDTH, 64, request address width.
- BLOCK_WIDTH, 512, cache block width (data in and out).
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-channel request; held high until that channel's done pulse.
- req_wr  in  NUM_REQ  per-channel: 1 = block write, 0 = block read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; channel i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*BLOCK_WIDTH  packed write blocks.
- done  out  NUM_REQ  one-cycle completion pulse, one-hot or zero.
- rdata  out  BLOCK_WIDTH  read block, valid while done is high; shared by all channels.
- grant_id  out  $clog2(NUM_REQ)  current or last granted channel (debug and perf).
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  one-cycle start pulse to memory_controller.
- mem_addr  out  ADDR_WIDTH  registered address of the granted request.
- mem_wr_en  out  1  registered write flag.
- mem_wdata  out  BLOCK_WIDTH  registered write block.
- mem_data_valid  in  1  memory_controller completion, one cycle.
- mem_rdata  in  BLOCK_WIDTH  block data, valid with mem_data_valid.

Behaviour:
- Reset values: done = 0, rdata = 0, grant_id = 0, busy = 0, mem_req = 0, mem_addr = 0, mem_wr_en = 0, mem_wdata = 0. The round-robin pointer resets to 0 and the FSM to IDLE. Reset mid-transaction abandons the transaction; a mem_data_valid arriving after reset in IDLE is ignored.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is high, select a winner in the same cycle.
  - Fixed mode: lowest asserted index wins.
  - RR mode: first asserted index at or after the pointer, wrapping NUM_REQ-1 → 0.
  - On selection, latch grant_id and the winner's addr, wr and wdata; go to ISSUE.
- ISSUE: mem_req = 1 for exactly this cycle; go to WAIT.
- WAIT: hold mem_addr, mem_wr_en and mem_wdata stable. When mem_data_valid is high:
  - capture mem_rdata into rdata for reads; for writes rdata keeps its previous value;
  - go to RESP.
- RESP: done[grant_id] = 1 for one cycle; rdata is valid.
  - RR pointer ← grant_id+1, wrapping at NUM_REQ.
  - Go to IDLE.
- Minimum latency: req_valid at cycle 0 → mem_req at cycle 1 → mem_data_valid at cycle ≥2 (call it cycle k) → done at k+1.
- Back-to-back: after RESP, a new arbitration is evaluated in IDLE on the following cycle. Turnaround from done to the next mem_req is 2 cycles.
- Grant lock: no re-arbitration between ISSUE and RESP. Requests arriving meanwhile wait.
- Withdrawal: if the granted channel drops req_valid after grant, the memory operation still completes. done is still pulsed, and the requester ignores it.
- mem_data_valid in IDLE, ISSUE or RESP is ignored. Only WAIT consumes it.
- Requesters must change req_addr, req_wr and req_wdata only while not granted. After latch, these inputs are don't-care.
- Starvation bound, RR mode: any continuously asserted request is granted within NUM_REQ grants.
- Non-power-of-2 NUM_REQ: the pointer wraps explicitly, with no modulo by truncation.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP);
  - the default ADDR_WIDTH and BLOCK_WIDTH constants;
  - a mem_req_t struct {addr, wr, wdata} for the latched request.
- One sub-module, rr_picker: combinational. It takes the request vector and the pointer and returns a one-hot grant, its index, and a valid flag. The fixed mode is obtained by tying pointer = 0.

Test Plan:
- Single read: ch0 read addr 0x1000; memory_controller model returns 0xA5-pattern block 5 cycles after mem_req → mem_req pulses at cycle 1 with mem_addr = 0x1000 and mem_wr_en = 0; done = 2'b01 at cycle 7 with rdata = the pattern.
- Write: ch1 write addr 0x2040, wdata = 0xDEAD…; mem_data_valid 3 cycles later → mem_wr_en = 1, mem_wdata matches; done = 2'b10 at cycle 5; rdata unchanged.
- RR fairness, NUM_REQ = 3: all channels held valid for 6 transactions → grant order 0,1,2,0,1,2; each done one-hot.
- Fixed priority (RR_MODE = 0), NUM_REQ = 3: ch0 and ch2 both held valid → ch0 granted on every transaction; ch2 granted only after ch0 drops req_valid.
- Withdrawal and spurious completion: ch0 drops req_valid in WAIT; an extra mem_data_valid is injected in IDLE → done[0] still pulses once; the spurious valid produces no done and no state change.
- Reset mid-WAIT: assert reset for 1 cycle in WAIT, then mem_data_valid arrives → all outputs 0, FSM in IDLE, no done pulse, pointer = 0.
